// File: rtl/dac_seq_pkg.sv
// Shared definitions for the DAC source sequencer: FSM state encoding,
// modulator source encodings and the default gain width.
package dac_seq_pkg;

    typedef enum logic [2:0] {
        ST_MUTED     = 3'd0,
        ST_FLUSH     = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_RUN       = 3'd3,
        ST_RAMP_DOWN = 3'd4
    } state_e;

    localparam logic SRC_PCM = 1'b0;
    localparam logic SRC_DSD = 1'b1;

    localparam int GAIN_W_DEF = 16;

endpackage

// File: rtl/dac_seq_sync.sv
// Brings the asynchronous DSD-request pin into the clk_i domain.
// Optional build macro DAC_SEQ_DEBOUNCE_EN: the synchronised level must be
// stable for DEBOUNCE_CYCLES consecutive cycles before tgt_o follows it.
module dac_seq_sync #(
    parameter int UNUSED_W = 1
`ifdef DAC_SEQ_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 1024
`endif
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [UNUSED_W-1:0] dsd_req_i,
    output logic                tgt_o
);

    logic sync1_q;
    logic sync2_q;

    // Two-flop synchroniser on the raw pin level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= dsd_req_i[0];
            sync2_q <= sync1_q;
        end
    end

`ifdef DAC_SEQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             tgt_q;
    logic             tgt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive cycles the synchronised level differs from tgt
    always_comb begin
        tgt_d = tgt_q;
        cnt_d = cnt_q;
        if (sync2_q == tgt_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            tgt_d = sync2_q;
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tgt_q <= 1'b0;
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            tgt_q <= tgt_d;
            cnt_q <= cnt_d;
        end
    end

    assign tgt_o = tgt_q;
`else
    assign tgt_o = sync2_q;
`endif

endmodule

// File: rtl/dac_src_sequencer.sv
// Sigma-delta output path sequencer: picks PCM or DSD as modulator source
// and wraps every source change, mute request or clock loss in a soft-mute
// gain ramp (flush at zero gain, ramp up, run, ramp down).
// Optional build macro DAC_SEQ_DEBOUNCE_EN enables dsd_req debouncing.
module dac_src_sequencer
    import dac_seq_pkg::*;
#(
    parameter int GAIN_W         = GAIN_W_DEF,
    parameter int RAMP_STEP      = 64,
    parameter int FLUSH_SAMPLES  = 32,
    parameter int TIMEOUT_CYCLES = 4096
`ifdef DAC_SEQ_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 1024
`endif
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sample_stb_i,
    input  logic              dsd_req_i,
    input  logic              mute_req_i,
    output logic              src_sel_o,
    output logic [GAIN_W-1:0] gain_o,
    output logic              dsm_rst_o,
    output logic              busy_o,
    output logic [2:0]        state_o,
    output logic              timeout_o
);

    localparam int                GW1      = GAIN_W + 1;
    localparam int                FL_W     = $clog2(FLUSH_SAMPLES + 1);
    localparam int                WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAIN_W-1:0] GAIN_MAX = {GAIN_W{1'b1}};
    localparam logic [GAIN_W-1:0] STEP     = GAIN_W'(RAMP_STEP);

    state_e            state_q,     state_d;
    logic [GAIN_W-1:0] gain_q,      gain_d;
    logic              src_sel_q,   src_sel_d;
    logic              dsm_rst_q,   dsm_rst_d;
    logic              busy_q,      busy_d;
    logic              timeout_q,   timeout_d;
    logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [WD_W-1:0]   wd_q,        wd_d;

    logic              tgt_s;
    logic [GW1-1:0]    gain_sum_s;
    logic [GAIN_W-1:0] gain_up_s;
    logic [GAIN_W-1:0] gain_dn_s;
    logic              req_drop_s;
    logic              timeout_evt_s;

    dac_seq_sync #(
        .UNUSED_W        (1)
`ifdef DAC_SEQ_DEBOUNCE_EN
        , .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
    ) u_sync (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .dsd_req_i (dsd_req_i),
        .tgt_o     (tgt_s)
    );

    // Saturating gain steps; the up-step is formed one bit wider so overflow is visible
    assign gain_sum_s = {1'b0, gain_q} + GW1'(RAMP_STEP);
    assign gain_up_s  = gain_sum_s[GAIN_W] ? GAIN_MAX : gain_sum_s[GAIN_W-1:0];
    assign gain_dn_s  = (gain_q < STEP) ? {GAIN_W{1'b0}} : (gain_q - STEP);

    // Leave the audible states when muting or when the requested source differs
    assign req_drop_s = mute_req_i | (tgt_s != src_sel_q);

    // A strobe in the same cycle as the last watchdog count suppresses the timeout
    assign timeout_evt_s = (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) && !sample_stb_i
                           && (state_q != ST_MUTED);

    // Next-state logic for the sequencer, watchdog and flush counter
    always_comb begin
        state_d     = state_q;
        gain_d      = gain_q;
        src_sel_d   = src_sel_q;
        flush_cnt_d = flush_cnt_q;
        timeout_d   = 1'b0;

        if (sample_stb_i) begin
            wd_d = {WD_W{1'b0}};
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES)) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end

        if (timeout_evt_s) begin
            // Clock loss: cut gain at once rather than ramping without strobes
            state_d   = ST_MUTED;
            gain_d    = {GAIN_W{1'b0}};
            timeout_d = 1'b1;
        end else begin
            case (state_q)
                ST_MUTED: begin
                    gain_d = {GAIN_W{1'b0}};
                    if (sample_stb_i && !mute_req_i) begin
                        src_sel_d   = tgt_s;
                        flush_cnt_d = {FL_W{1'b0}};
                        state_d     = ST_FLUSH;
                    end else begin
                        state_d = ST_MUTED;
                    end
                end
                ST_FLUSH: begin
                    gain_d = {GAIN_W{1'b0}};
                    if (req_drop_s) begin
                        state_d = ST_MUTED;
                    end else if (sample_stb_i) begin
                        if (flush_cnt_q == FL_W'(FLUSH_SAMPLES - 1)) begin
                            flush_cnt_d = {FL_W{1'b0}};
                            state_d     = ST_RAMP_UP;
                        end else begin
                            flush_cnt_d = flush_cnt_q + FL_W'(1);
                        end
                    end else begin
                        flush_cnt_d = flush_cnt_q;
                    end
                end
                ST_RAMP_UP: begin
                    if (req_drop_s) begin
                        state_d = ST_RAMP_DOWN;
                    end else if (sample_stb_i) begin
                        gain_d = gain_up_s;
                        if (gain_up_s == GAIN_MAX) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_RAMP_UP;
                        end
                    end else begin
                        state_d = ST_RAMP_UP;
                    end
                end
                ST_RUN: begin
                    gain_d = GAIN_MAX;
                    if (req_drop_s) begin
                        state_d = ST_RAMP_DOWN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (!req_drop_s) begin
                        state_d = ST_RAMP_UP;
                    end else if (sample_stb_i) begin
                        gain_d = gain_dn_s;
                        if (gain_dn_s == {GAIN_W{1'b0}}) begin
                            state_d = ST_MUTED;
                        end else begin
                            state_d = ST_RAMP_DOWN;
                        end
                    end else begin
                        state_d = ST_RAMP_DOWN;
                    end
                end
                default: begin
                    state_d = ST_MUTED;
                    gain_d  = {GAIN_W{1'b0}};
                end
            endcase
        end

        dsm_rst_d = (state_d == ST_MUTED);
        busy_d    = (state_d == ST_FLUSH) || (state_d == ST_RAMP_UP) ||
                    (state_d == ST_RAMP_DOWN);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_MUTED;
            gain_q      <= {GAIN_W{1'b0}};
            src_sel_q   <= SRC_PCM;
            dsm_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            flush_cnt_q <= {FL_W{1'b0}};
            wd_q        <= {WD_W{1'b0}};
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            src_sel_q   <= src_sel_d;
            dsm_rst_q   <= dsm_rst_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            flush_cnt_q <= flush_cnt_d;
            wd_q        <= wd_d;
        end
    end

    assign src_sel_o = src_sel_q;
    assign gain_o    = gain_q;
    assign dsm_rst_o = dsm_rst_q;
    assign busy_o    = busy_q;
    assign state_o   = state_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_dac_src_sequencer.sv
// Directed self-checking bench for dac_src_sequencer (default parameters,
// sample strobe every 4 clk cycles to keep the run short).
module tb_dac_src_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        sample_stb_i = 1'b0;
    logic        dsd_req_i = 1'b0;
    logic        mute_req_i = 1'b0;
    logic        src_sel_o;
    logic [15:0] gain_o;
    logic        dsm_rst_o;
    logic        busy_o;
    logic [2:0]  state_o;
    logic        timeout_o;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int src_viol = 0;
    logic prev_src = 1'b0;

    dac_src_sequencer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .sample_stb_i (sample_stb_i),
        .dsd_req_i    (dsd_req_i),
        .mute_req_i   (mute_req_i),
        .src_sel_o    (src_sel_o),
        .gain_o       (gain_o),
        .dsm_rst_o    (dsm_rst_o),
        .busy_o       (busy_o),
        .state_o      (state_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Source select must never move while gain is non-zero
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (src_sel_o !== prev_src && gain_o !== 16'h0000) src_viol <= src_viol + 1;
            prev_src <= src_sel_o;
        end
    end

    // n strobes, one every 4 cycles; returns 2.5 cycles after the last strobe edge
    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i); sample_stb_i = 1'b1;
            @(negedge clk_i); sample_stb_i = 1'b0;
            @(negedge clk_i);
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        chk_cnt++; if (state_o !== 3'd0) $display("FAIL rst_state: got %0d expected 0", state_o); else pass_cnt++;
        chk_cnt++; if (gain_o !== 16'h0000) $display("FAIL rst_gain: got %h expected 0000", gain_o); else pass_cnt++;
        chk_cnt++; if (src_sel_o !== 1'b0) $display("FAIL rst_src: got %b expected 0", src_sel_o); else pass_cnt++;
        chk_cnt++; if (dsm_rst_o !== 1'b1) $display("FAIL rst_dsm: got %b expected 1", dsm_rst_o); else pass_cnt++;
        chk_cnt++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy_o); else pass_cnt++;
        chk_cnt++; if (timeout_o !== 1'b0) $display("FAIL rst_timeout: got %b expected 0", timeout_o); else pass_cnt++;
        rst_ni = 1'b1;
    endtask

    task automatic test_ramp_up();
        pulse(1);
        chk_cnt++; if (state_o !== 3'd1) $display("FAIL t1_flush_state: got %0d expected 1", state_o); else pass_cnt++;
        chk_cnt++; if (dsm_rst_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL t1_flush_flags: got dsm=%b busy=%b expected 0/1", dsm_rst_o, busy_o); else pass_cnt++;
        pulse(31);
        chk_cnt++; if (state_o !== 3'd1) $display("FAIL t1_flush_31: got %0d expected 1", state_o); else pass_cnt++;
        pulse(1);
        chk_cnt++; if (state_o !== 3'd2 || gain_o !== 16'h0000) $display("FAIL t1_ramp_entry: got st=%0d g=%h expected 2/0000", state_o, gain_o); else pass_cnt++;
        pulse(1);
        chk_cnt++; if (gain_o !== 16'h0040) $display("FAIL t1_first_step: got %h expected 0040", gain_o); else pass_cnt++;
        pulse(1022);
        chk_cnt++; if (gain_o !== 16'hFFC0 || state_o !== 3'd2) $display("FAIL t1_pre_max: got g=%h st=%0d expected FFC0/2", gain_o, state_o); else pass_cnt++;
        pulse(1);
        chk_cnt++; if (gain_o !== 16'hFFFF || state_o !== 3'd3 || busy_o !== 1'b0) $display("FAIL t1_run: got g=%h st=%0d busy=%b expected FFFF/3/0", gain_o, state_o, busy_o); else pass_cnt++;
        chk_cnt++; if (src_sel_o !== 1'b0) $display("FAIL t1_src: got %b expected 0", src_sel_o); else pass_cnt++;
    endtask

    task automatic test_source_change();
        dsd_req_i = 1'b1;
`ifdef DAC_SEQ_DEBOUNCE_EN
        repeat (1100) @(negedge clk_i);
`else
        repeat (2) @(negedge clk_i);
        chk_cnt++; if (state_o !== 3'd3) $display("FAIL t2_sync_lag: got %0d expected 3", state_o); else pass_cnt++;
        @(negedge clk_i);
`endif
        chk_cnt++; if (state_o !== 3'd4 || gain_o !== 16'hFFFF) $display("FAIL t2_rd_entry: got st=%0d g=%h expected 4/FFFF", state_o, gain_o); else pass_cnt++;
        pulse(1023);
        chk_cnt++; if (gain_o !== 16'h003F || src_sel_o !== 1'b0) $display("FAIL t2_rd_tail: got g=%h src=%b expected 003F/0", gain_o, src_sel_o); else pass_cnt++;
        pulse(1);
        chk_cnt++; if (gain_o !== 16'h0000 || state_o !== 3'd0 || dsm_rst_o !== 1'b1) $display("FAIL t2_muted: got g=%h st=%0d dsm=%b expected 0000/0/1", gain_o, state_o, dsm_rst_o); else pass_cnt++;
        pulse(1);
        chk_cnt++; if (state_o !== 3'd1 || src_sel_o !== 1'b1) $display("FAIL t2_dsd_flush: got st=%0d src=%b expected 1/1", state_o, src_sel_o); else pass_cnt++;
        pulse(33);
        chk_cnt++; if (gain_o !== 16'h0040 || state_o !== 3'd2) $display("FAIL t2_dsd_ramp: got g=%h st=%0d expected 0040/2", gain_o, state_o); else pass_cnt++;
    endtask

    task automatic test_mute_ramp();
        pulse(255);
        chk_cnt++; if (gain_o !== 16'h4000) $display("FAIL t3_at_4000: got %h expected 4000", gain_o); else pass_cnt++;
        mute_req_i = 1'b1;
        @(negedge clk_i);
        chk_cnt++; if (state_o !== 3'd4 || gain_o !== 16'h4000) $display("FAIL t3_mute_rd: got st=%0d g=%h expected 4/4000", state_o, gain_o); else pass_cnt++;
        pulse(128);
        chk_cnt++; if (gain_o !== 16'h2000) $display("FAIL t3_at_2000: got %h expected 2000", gain_o); else pass_cnt++;
        mute_req_i = 1'b0;
        @(negedge clk_i);
        chk_cnt++; if (state_o !== 3'd2 || gain_o !== 16'h2000) $display("FAIL t3_resume: got st=%0d g=%h expected 2/2000", state_o, gain_o); else pass_cnt++;
        pulse(1);
        chk_cnt++; if (gain_o !== 16'h2040) $display("FAIL t3_resume_step: got %h expected 2040", gain_o); else pass_cnt++;
        pulse(127);
        mute_req_i = 1'b1;
        @(negedge clk_i);
        pulse(255);
        chk_cnt++; if (gain_o !== 16'h0040 || state_o !== 3'd4) $display("FAIL t3_rd_255: got g=%h st=%0d expected 0040/4", gain_o, state_o); else pass_cnt++;
        pulse(1);
        chk_cnt++; if (gain_o !== 16'h0000 || state_o !== 3'd0 || dsm_rst_o !== 1'b1) $display("FAIL t3_rd_256: got g=%h st=%0d dsm=%b expected 0000/0/1", gain_o, state_o, dsm_rst_o); else pass_cnt++;
        mute_req_i = 1'b0;
    endtask

    task automatic test_timeout();
        int to_at;
        int extra;
        to_at = -1;
        extra = 0;
        pulse(1057);
        chk_cnt++; if (state_o !== 3'd3 || gain_o !== 16'hFFFF) $display("FAIL t4_run: got st=%0d g=%h expected 3/FFFF", state_o, gain_o); else pass_cnt++;
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk_i);
            if (timeout_o === 1'b1) begin
                to_at = i;
                break;
            end
        end
        chk_cnt++; if (to_at !== 4094) $display("FAIL t4_timeout_at: got %0d expected 4094", to_at); else pass_cnt++;
        chk_cnt++; if (gain_o !== 16'h0000 || dsm_rst_o !== 1'b1 || state_o !== 3'd0) $display("FAIL t4_timeout_out: got g=%h dsm=%b st=%0d expected 0000/1/0", gain_o, dsm_rst_o, state_o); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (timeout_o === 1'b1) extra++;
        end
        chk_cnt++; if (extra !== 0) $display("FAIL t4_single_pulse: got %0d extra pulses expected 0", extra); else pass_cnt++;
        pulse(1);
        chk_cnt++; if (state_o !== 3'd1 || src_sel_o !== 1'b1) $display("FAIL t4_restart: got st=%0d src=%b expected 1/1", state_o, src_sel_o); else pass_cnt++;
        for (int i = 0; i < 4093; i++) begin
            @(negedge clk_i);
            if (timeout_o === 1'b1) extra++;
        end
        sample_stb_i = 1'b1;
        @(negedge clk_i);
        sample_stb_i = 1'b0;
        if (timeout_o === 1'b1) extra++;
        repeat (3) @(negedge clk_i);
        chk_cnt++; if (extra !== 0 || state_o !== 3'd1) $display("FAIL t4_strobe_wins: got pulses=%0d st=%0d expected 0/1", extra, state_o); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        pulse(31);
        pulse(10);
        chk_cnt++; if (gain_o !== 16'h0280 || state_o !== 3'd2) $display("FAIL t5_pre: got g=%h st=%0d expected 0280/2", gain_o, state_o); else pass_cnt++;
        mute_req_i = 1'b1;
        @(negedge clk_i);
        pulse(1);
        chk_cnt++; if (gain_o !== 16'h0240 || state_o !== 3'd4) $display("FAIL t5_rd: got g=%h st=%0d expected 0240/4", gain_o, state_o); else pass_cnt++;
        #3;
        rst_ni = 1'b0;
        #1;
        chk_cnt++; if (state_o !== 3'd0 || gain_o !== 16'h0000) $display("FAIL t5_async_sg: got st=%0d g=%h expected 0/0000", state_o, gain_o); else pass_cnt++;
        chk_cnt++; if (src_sel_o !== 1'b0 || dsm_rst_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL t5_async_flags: got src=%b dsm=%b busy=%b expected 0/1/0", src_sel_o, dsm_rst_o, busy_o); else pass_cnt++;
        mute_req_i = 1'b0;
        dsd_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

`ifdef DAC_SEQ_DEBOUNCE_EN
    task automatic test_debounce();
        pulse(1057);
        chk_cnt++; if (state_o !== 3'd3) $display("FAIL t6_run: got %0d expected 3", state_o); else pass_cnt++;
        dsd_req_i = 1'b1;
        repeat (500) @(negedge clk_i);
        dsd_req_i = 1'b0;
        repeat (20) @(negedge clk_i);
        chk_cnt++; if (state_o !== 3'd3 || gain_o !== 16'hFFFF) $display("FAIL t6_glitch: got st=%0d g=%h expected 3/FFFF", state_o, gain_o); else pass_cnt++;
        dsd_req_i = 1'b1;
        repeat (1000) @(negedge clk_i);
        chk_cnt++; if (state_o !== 3'd3) $display("FAIL t6_hold_early: got %0d expected 3", state_o); else pass_cnt++;
        repeat (100) @(negedge clk_i);
        chk_cnt++; if (state_o !== 3'd4) $display("FAIL t6_hold_1100: got %0d expected 4", state_o); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_ramp_up();
        test_source_change();
        test_mute_ramp();
        test_timeout();
        test_async_reset();
`ifdef DAC_SEQ_DEBOUNCE_EN
        test_debounce();
`endif
        chk_cnt++; if (src_viol !== 0) $display("FAIL src_while_gain: got %0d changes expected 0", src_viol); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
